event_encoder: RTL
==================

EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 SHALL have parameter SYNC_EN, default 1, meaning 1 = two-flop synchronizer on req_n and 0 = req_n sampled directly.
REQ-002 SHALL have port clk, input, 1, the single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port en_n, input, 1, active-low capture enable.
REQ-005 SHALL have port req_n, input, 16, active-low event lines, idle high.
REQ-006 SHALL have port code, output, 4, encoded index of the presented event.
REQ-007 SHALL have port valid, output, 1, meaning code holds a presented event.
REQ-008 SHALL have port ack, input, 1, consumer acceptance of the presented code.
REQ-009 SHALL have port pending, output, 16, active-high vector of captured, not-yet-presented events.
REQ-010 SHALL have port lost, output, 1, one-cycle pulse when an event hits a line already pending.

Function
REQ-011 SHALL detect an event on line i as a falling edge: previous sampled req_n[i]=1 and current sampled req_n[i]=0.
REQ-012 SHALL set pending[i] on the edge after the detected event only while en_n=0; with en_n=1, events are discarded, while the previous-sample register still updates and presentation continues.
REQ-013 SHALL, with SYNC_EN=0, show pending[i]=1 one clock after req_n[i] is first sampled low, and valid=1 one clock later if the block is idle; SYNC_EN=1 adds exactly 2 clocks.
REQ-014 SHALL implement FSM states IDLE and PRESENT.
REQ-015 SHALL, in IDLE with pending nonzero, select the lowest-index set bit at or above rr_ptr, wrapping 15->0.
REQ-016 SHALL, on that selection, register code, set valid, clear the chosen pending bit and enter PRESENT.
REQ-017 SHALL hold code and valid stable in PRESENT until ack=1 is sampled.
REQ-018 SHALL, on an acked edge in PRESENT, clear valid, load rr_ptr with code+1 modulo 16 (15 wraps to 0) and return to IDLE.
REQ-019 SHALL make the earliest next valid the clock after the return to IDLE, giving a minimum of one valid-low cycle between grants.
REQ-020 SHALL ignore ack while valid=0.
REQ-021 SHALL let set win if an event on line i arrives in the same cycle pending[i] is cleared by selection.
REQ-022 SHALL, for an event on a line whose pending bit is already 1 and not being cleared, leave pending unchanged and pulse lost for one clock.
REQ-023 SHALL capture simultaneous events on several lines in the same cycle, with no loss.
REQ-024 SHALL hold code at its last value while valid=0.

Reset
REQ-025 SHALL, while reset_n=0 at a clock edge, set code=0, valid=0, pending=0, lost=0, rr_ptr=0, state=IDLE, and set the synchronizer and previous-sample registers to all ones.
REQ-026 SHALL let reset mid-PRESENT drop valid on the next edge, with the pending event discarded.
REQ-027 SHALL not report lines held low through reset release as events until they return high and fall again.

Structure
REQ-028 SHALL place N_LINES=16, IDX_W=4 and the FSM state type in package event_encoder_pkg.
REQ-029 SHALL place the combinational round-robin selection (16-bit request plus 4-bit pointer in; 4-bit index plus found flag out) in sub-module rr_pick16.
REQ-030 SHALL keep all other logic, including synchronizer, edge detect, pending register and FSM, in event_encoder.

Verification
REQ-031 SHALL cover a single event: SYNC_EN=0, en_n=0, req_n[5] falls at cycle 0 -> pending=0x0020 at cycle 1, code=5 and valid=1 at cycle 2; ack at cycle 4 -> valid=0 at cycle 5.
REQ-032 SHALL cover round-robin ordering: rr_ptr=0, req_n[3], req_n[9] and req_n[0] fall together -> codes 0, 3, 9 in order, rr_ptr=10 after the last ack.
REQ-033 SHALL cover wrap-around: after code 14 is acked, lines 15 and 2 pending -> next code=15, then code=2.
REQ-034 SHALL cover lost events and set-wins: line 7 falls twice while pending -> lost pulses once and a single code 7 is presented; a re-fall on line 7 in its selection cycle -> a second code 7 is presented later.
REQ-035 SHALL cover enable and reset: en_n=1 while line 4 falls -> pending stays 0; reset_n=0 during PRESENT -> valid=0, pending=0 next cycle, and line 4 held low causes no event after release.

Source files
------------

// File: rtl/event_encoder_pkg.sv
// event_encoder_pkg
// Shared constants and the FSM state type for the event encoder.
//   N_LINES : number of event lines
//   IDX_W   : width of an encoded line index
//   state_t : presentation FSM states
package event_encoder_pkg;
   localparam int N_LINES = 16;
   localparam int IDX_W   = 4;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;
endpackage

// File: rtl/event_encoder_rr_pick16.sv
// rr_pick16
// Combinational round-robin picker: returns the lowest-index set request
// bit at or above ptr, wrapping from the top line back to line 0.
//   req   : request vector, one bit per line
//   ptr   : round-robin start position
//   idx   : chosen line (0 when nothing is requested)
//   found : at least one request bit is set
module rr_pick16
   import event_encoder_pkg::*;
(
   input  logic [N_LINES-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   logic [IDX_W-1:0] j;

   // Walk the ring from the far end back toward ptr so that the candidate
   // closest to ptr is the last one written and therefore wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int k = N_LINES - 1; k >= 0; k--) begin
         j = ptr + IDX_W'(k);
         if (req[j]) begin
            idx   = j;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/event_encoder.sv
// event_encoder
// Captures falling edges on 16 active-low event lines into a pending vector
// and presents them one at a time, round-robin, to a consumer with a
// valid/ack handshake.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   en_n     : active-low capture enable (events dropped while high)
//   req_n    : active-low event lines, idle high
//   code     : index of the presented event (holds while valid=0)
//   valid    : code holds a presented event
//   ack      : consumer accepts the presented code
//   pending  : captured events not yet presented
//   lost     : one-cycle pulse when an event hits an already pending line
module event_encoder
   import event_encoder_pkg::*;
#(
   parameter bit SYNC_EN = 1'b1
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en_n,
   input  logic [N_LINES-1:0] req_n,
   output logic [IDX_W-1:0]   code,
   output logic               valid,
   input  logic               ack,
   output logic [N_LINES-1:0] pending,
   output logic               lost
);

   logic [N_LINES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_LINES-1:0] prev_q, prev_d, armed_q, armed_d;
   logic [N_LINES-1:0] pending_q, pending_d;
   logic [1:0]         live_q, live_d;
   logic               lost_q, lost_d, valid_q, valid_d;
   logic [IDX_W-1:0]   code_q, code_d, rr_ptr_q, rr_ptr_d;
   state_t             state_q, state_d;

   logic [N_LINES-1:0] sampled, ev, ev_cap, clr;
   logic               live_ok;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;

   rr_pick16 u_pick (
      .req   (pending_q),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      sampled = SYNC_EN ? sync2_q : req_n;
      // live_ok marks the first cycle in which 'sampled' reflects the pins
      // rather than the all-ones reset contents of the synchronizer.
      live_ok = SYNC_EN ? live_q[1] : 1'b1;

      sync1_d = req_n;
      sync2_d = sync1_q;
      prev_d  = sampled;
      live_d  = {live_q[0], 1'b1};

      // A line only becomes eligible for edge detection once it has been
      // genuinely seen high, so a line held low across reset release does
      // not look like a fall against the all-ones reset value of prev_q.
      armed_d = armed_q | (sampled & {N_LINES{live_ok}});
      ev      = armed_q & prev_q & ~sampled;
      ev_cap  = en_n ? '0 : ev;

      state_d  = state_q;
      code_d   = code_q;
      valid_d  = valid_q;
      rr_ptr_d = rr_ptr_q;
      clr      = '0;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               code_d  = pick_idx;
               valid_d = 1'b1;
               clr     = N_LINES'(1) << pick_idx;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (ack) begin
               valid_d  = 1'b0;
               rr_ptr_d = code_q + 1'b1;   // wraps 15 -> 0 by width
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Set wins over the selection clear on the same line.
      pending_d = (pending_q & ~clr) | ev_cap;
      lost_d    = |(ev_cap & pending_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         prev_q    <= '1;
         armed_q   <= '0;
         live_q    <= '0;
         pending_q <= '0;
         lost_q    <= 1'b0;
         valid_q   <= 1'b0;
         code_q    <= '0;
         rr_ptr_q  <= '0;
         state_q   <= ST_IDLE;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         armed_q   <= armed_d;
         live_q    <= live_d;
         pending_q <= pending_d;
         lost_q    <= lost_d;
         valid_q   <= valid_d;
         code_q    <= code_d;
         rr_ptr_q  <= rr_ptr_d;
         state_q   <= state_d;
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign pending = pending_q;
   assign lost    = lost_q;

endmodule
